float_div_seq: RTL and testbench

Sequential floating-point divider for the LM32 coprocessor datapath, in the `float_pack` format: sign, `Ne`-bit biased exponent, `Nm`-bit mantissa with hidden one. It computes the quotient with a restoring radix-2 divider that produces one quotient bit per cycle, which keeps area small compared with a single-cycle divide. Operands are accepted through a start/busy/done handshake from the coprocessor decode stage.

---
 rtl/float_div_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_float_div_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/float_div_seq.sv
// float_div_seq: sequential floating-point divider for the float_pack format
// {sign, Ne-bit biased exponent, Nm-bit mantissa with hidden one}.
// A restoring radix-2 divider produces one quotient bit per clock.
// Operands are accepted through a start/busy/done handshake.
// Optional build macro FLOAT_DIV_ROUND_EN adds one guard bit and a RND state
// (round half up). Without it the quotient is truncated toward zero.
module float_div_seq #(
    parameter int Nm = 23,
    parameter int Ne = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic [Ne+Nm:0]  a_i,
    input  logic [Ne+Nm:0]  b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [Ne+Nm:0]  result_o
);

    localparam int W  = 1 + Ne + Nm;
    localparam int EW = Ne + 2;
`ifdef FLOAT_DIV_ROUND_EN
    localparam int QW = Nm + 3;     // quotient bits including one guard bit
`else
    localparam int QW = Nm + 2;
`endif
    localparam int CW = $clog2(QW + 1);

    localparam logic signed [EW-1:0] BIAS   = EW'(2**(Ne-1) - 1);
    localparam logic signed [EW-1:0] MAX_E  = EW'(2**Ne - 1);
    localparam logic signed [EW-1:0] SAT_E  = EW'(2**Ne - 2);
    localparam logic signed [EW-1:0] ZERO_E = '0;
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic [Ne-1:0]        SAT_EXP = {{(Ne-1){1'b1}}, 1'b0};

`ifdef FLOAT_DIV_ROUND_EN
    typedef enum logic [2:0] {IDLE, SPEC, CALC, NORM, RND} state_t;
`else
    typedef enum logic [1:0] {IDLE, SPEC, CALC, NORM} state_t;
`endif

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic signed [EW-1:0]   e_tmp_q, e_tmp_d;
    logic [Nm+1:0]          rem_q, rem_d;
    logic [Nm:0]            div_q, div_d;
    logic [QW-1:0]          quo_q, quo_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-1:0]           spec_q, spec_d;     // pending result (special case or pre-round value)
    logic [W-1:0]           result_q, result_d;
    logic                   done_q, done_d;
`ifdef FLOAT_DIV_ROUND_EN
    logic                   guard_q, guard_d;
    logic                   final_q, final_d;   // pending value already flushed/saturated, skip rounding
`endif

    // Operand fields and special-case detection at the request
    logic [Ne-1:0]          a_exp, b_exp;
    logic [Nm-1:0]          a_man, b_man;
    logic                   a_zero, b_zero, sign_in;
    logic signed [EW-1:0]   e_calc;

    assign a_exp   = a_i[W-2:Nm];
    assign b_exp   = b_i[W-2:Nm];
    assign a_man   = a_i[Nm-1:0];
    assign b_man   = b_i[Nm-1:0];
    assign a_zero  = (a_exp == '0) && (a_man == '0);
    assign b_zero  = (b_exp == '0) && (b_man == '0);
    assign sign_in = a_i[W-1] ^ b_i[W-1];
    assign e_calc  = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;

    // One restoring-division step
    logic                   rem_ge;
    logic [Nm+1:0]          rem_diff;

    assign rem_ge   = (rem_q >= {1'b0, div_q});
    assign rem_diff = rem_q - {1'b0, div_q};

    // Normalisation: quotient lies in (0.5, 2), the top bit tells which half
    logic                   q_top;
    logic signed [EW-1:0]   e_norm;
    logic [Nm-1:0]          mant_n;

    assign q_top  = quo_q[QW-1];
    assign e_norm = q_top ? e_tmp_q : (e_tmp_q - ONE_E);
`ifdef FLOAT_DIV_ROUND_EN
    logic                   guard_n;
    logic [Nm:0]            mant_sum;
    logic [Ne:0]            exp_r;

    assign mant_n   = q_top ? quo_q[Nm+1:2] : quo_q[Nm:1];
    assign guard_n  = q_top ? quo_q[1] : quo_q[0];
    // Rounding increment; a mantissa carry-out bumps the exponent and leaves mant zero
    assign mant_sum = {1'b0, spec_q[Nm-1:0]} + {{Nm{1'b0}}, guard_q};
    assign exp_r    = {1'b0, spec_q[W-2:Nm]} + {{Ne{1'b0}}, mant_sum[Nm]};
`else
    assign mant_n   = q_top ? quo_q[Nm:1] : quo_q[Nm-1:0];
`endif

    // Next-state and datapath update for every state
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        e_tmp_d  = e_tmp_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        spec_d   = spec_q;
        result_d = result_q;
        done_d   = 1'b0;
`ifdef FLOAT_DIV_ROUND_EN
        guard_d  = guard_q;
        final_d  = final_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sign_d  = sign_in;
                    e_tmp_d = e_calc;
                    rem_d   = {1'b0, 1'b1, a_man};
                    div_d   = {1'b1, b_man};
                    quo_d   = '0;
                    cnt_d   = CW'(QW);
                    state_d = SPEC;
                    if (a_zero)
                        spec_d = '0;
                    else if (b_zero)
                        spec_d = {1'b0, {Ne{1'b1}}, {Nm{1'b0}}};
                    else if (e_calc > MAX_E)
                        spec_d = {sign_in, SAT_EXP, {Nm{1'b1}}};
                    else if (e_calc < ZERO_E)
                        spec_d = {sign_in, {(W-1){1'b0}}};
                    else
                        state_d = CALC;
                end
            end
            SPEC: begin
                result_d = spec_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            CALC: begin
                if (rem_ge) begin
                    quo_d = {quo_q[QW-2:0], 1'b1};
                    rem_d = rem_diff << 1;
                end else begin
                    quo_d = {quo_q[QW-2:0], 1'b0};
                    rem_d = rem_q << 1;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = NORM;
            end
            NORM: begin
`ifdef FLOAT_DIV_ROUND_EN
                guard_d = guard_n;
                final_d = 1'b1;
                state_d = RND;
                if (e_norm <= ZERO_E)
                    spec_d = {sign_q, {(W-1){1'b0}}};
                else if (e_norm > SAT_E)
                    spec_d = {sign_q, SAT_EXP, {Nm{1'b1}}};
                else begin
                    spec_d  = {sign_q, e_norm[Ne-1:0], mant_n};
                    final_d = 1'b0;
                end
`else
                done_d  = 1'b1;
                state_d = IDLE;
                if (e_norm <= ZERO_E)
                    result_d = {sign_q, {(W-1){1'b0}}};
                else if (e_norm > SAT_E)
                    result_d = {sign_q, SAT_EXP, {Nm{1'b1}}};
                else
                    result_d = {sign_q, e_norm[Ne-1:0], mant_n};
`endif
            end
`ifdef FLOAT_DIV_ROUND_EN
            RND: begin
                done_d  = 1'b1;
                state_d = IDLE;
                // exponent is at least 1 here, so only saturation can follow rounding
                if (final_q)
                    result_d = spec_q;
                else if (exp_r > {1'b0, SAT_EXP})
                    result_d = {spec_q[W-1], SAT_EXP, {Nm{1'b1}}};
                else
                    result_d = {spec_q[W-1], exp_r[Ne-1:0], mant_sum[Nm-1:0]};
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            e_tmp_q  <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            spec_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
`ifdef FLOAT_DIV_ROUND_EN
            guard_q  <= 1'b0;
            final_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            e_tmp_q  <= e_tmp_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            spec_q   <= spec_d;
            result_q <= result_d;
            done_q   <= done_d;
`ifdef FLOAT_DIV_ROUND_EN
            guard_q  <= guard_d;
            final_q  <= final_d;
`endif
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_float_div_seq.sv
// Testbench for float_div_seq (Ne=8, Nm=23): directed cases from the
// expected behaviour plus random operands checked against an arithmetic model.
module tb_float_div_seq;

    localparam int NM = 23;
`ifdef FLOAT_DIV_ROUND_EN
    localparam int          LAT_N = NM + 5;
    localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
    localparam int          LAT_N = NM + 3;
    localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [31:0] a_i, b_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int tests = 0;
    int fails = 0;

    float_div_seq #(.Nm(23), .Ne(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer quotient of the significands, normalised into [1,2)
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
        logic              s;
        int                ea, eb, e, ex;
        longint unsigned   num, den, q;
        logic [22:0]       ma, mb;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = a[22:0];
        mb = b[22:0];
        e  = ea - eb + 127;
        lat = 1;
        r = '0;
        if (ea == 0 && ma == 0)
            r = 32'h0000_0000;
        else if (eb == 0 && mb == 0)
            r = 32'h7F80_0000;
        else if (e > 255)
            r = {s, 8'hFE, 23'h7FFFFF};
        else if (e < 0)
            r = {s, 31'd0};
        else begin
            lat = LAT_N;
            num = {40'd0, 1'b1, ma};
            den = {40'd0, 1'b1, mb};
            if (num >= den) ex = e;
            else begin
                ex  = e - 1;
                num = num << 1;
            end
`ifdef FLOAT_DIV_ROUND_EN
            q = (num << (NM + 1)) / den;
            if (ex <= 0) r = {s, 31'd0};
            else if (ex > 254) r = {s, 8'hFE, 23'h7FFFFF};
            else begin
                q = (q + 1) >> 1;
                if (q == (64'd1 << (NM + 1))) begin
                    q  = q >> 1;
                    ex = ex + 1;
                end
                if (ex > 254) r = {s, 8'hFE, 23'h7FFFFF};
                else          r = {s, 8'(ex), 23'(q)};
            end
`else
            q = (num << NM) / den;
            if (ex <= 0)       r = {s, 31'd0};
            else if (ex > 254) r = {s, 8'hFE, 23'h7FFFFF};
            else               r = {s, 8'(ex), 23'(q)};
`endif
        end
    endfunction

    function automatic logic [31:0] rand_op();
        int sel, e;
        sel = int'($urandom_range(0, 9));
        if (sel == 0) return 32'h0;
        e = (sel == 1) ? int'($urandom_range(1, 254)) : int'($urandom_range(70, 185));
        return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
    endfunction

    // Present operands and pulse start across one edge (E0)
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Wait for done (bounded), checking latency, result and busy behaviour
    task automatic wait_done(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_r, input int exp_lat, input int cyc0);
        int   cyc;
        logic busy_bad;
        cyc = cyc0;
        busy_bad = 1'b0;
        while (done_o !== 1'b1 && cyc < 200) begin
            if (busy_o !== 1'b1) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        $display("[TB] %s a=%h b=%h result=%h expected=%h edges=%0d", tag, a, b, result_o, exp_r, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_result"}, result_o, exp_r);
        check({tag, "_busy_at_done"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_busy_held"}, {31'd0, busy_bad}, 32'd0);
    endtask

    task automatic after_done(input string tag, input logic [31:0] exp_r);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
        check({tag, "_result_held"}, result_o, exp_r);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_lat);
        start_op(a, b);
        wait_done(tag, a, b, exp_r, exp_lat, 0);
        after_done(tag, exp_r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          lat, extra;

        reset_n = 1'b0;
        start_i = 1'b0;
        a_i = '0;
        b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        check("reset_result", result_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        run_op("six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000, LAT_N);
        run_op("one_div_three", 32'h3F800000, 32'h40400000, THIRD, LAT_N);
        run_op("div_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1);
        run_op("zero_dividend", 32'h00000000, 32'hC0A00000, 32'h00000000, 1);
        run_op("saturate", 32'h7F000000, 32'h3E800000, 32'h7F7FFFFF, 1);
        model(32'h80800000, 32'h40000000, r, lat);
        run_op("flush_neg", 32'h80800000, 32'h40000000, 32'h80000000, lat);

        // Reset at E10 of a running divide
        start_op(32'h40C00000, 32'h40000000);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_done", {31'd0, done_o}, 32'd0);
        check("abort_result", result_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o === 1'b1) extra++;
        end
        $display("[TB] abort: done pulses after reset release=%0d", extra);
        check("abort_no_done", 32'(extra), 32'd0);
        run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, LAT_N);

        // start_i pulsed during CALC is ignored
        start_op(32'h3F800000, 32'h40400000);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        start_op(32'h40C00000, 32'h40000000);
        wait_done("start_in_calc", 32'h3F800000, 32'h40400000, THIRD, LAT_N, 6);
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done_o === 1'b1 || busy_o === 1'b1) extra++;
        end
        check("ignored_start_no_op", 32'(extra), 32'd0);

        // Second start in the done cycle is accepted
        start_op(32'h40C00000, 32'h40000000);
        wait_done("b2b_first", 32'h40C00000, 32'h40000000, 32'h40400000, LAT_N, 0);
        start_op(32'h3F800000, 32'h40400000);
        wait_done("b2b_second", 32'h3F800000, 32'h40400000, THIRD, LAT_N, 0);
        after_done("b2b_second", THIRD);

        // Random operands, issued back-to-back
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb, rr;
            int          rl;
            ra = rand_op();
            rb = rand_op();
            model(ra, rb, rr, rl);
            start_op(ra, rb);
            wait_done($sformatf("rnd%0d", i), ra, rb, rr, rl, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
